// File: rtl/dlx_pkg.sv
// Shared DLX definitions: access sizes, write-back select values, MEM stage states
// and the alignment rule.
package dlx_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is handled as a word too

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ma_state_t;

  // A half access must be even; a word access (including size 11) must sit on a
  // 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Byte-lane steering for the memory stage. The load half selects a lane and
// extends it. The store half replicates the data and builds the byte enables.
module mem_load_align
  import dlx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] st_word,
  output logic [BE_WIDTH-1:0]   st_be
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // Load lane select and extension. Halves are always even, so one shift by
  // offset*8 serves both byte and half lanes.
  always_comb begin
    ld_half = 16'(rd_word >> {offset, 3'b000});
    ld_byte = ld_half[7:0];
    ld_data = rd_word;
    case (size)
      SIZE_BYTE: ld_data = {{(DATA_WIDTH-8){is_signed & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{(DATA_WIDTH-16){is_signed & ld_half[15]}}, ld_half};
      default:   ld_data = rd_word;
    endcase
  end

  // Store replication and byte enables (lane 0 = bits 7:0).
  always_comb begin
    st_word = st_data;
    st_be   = '1;
    case (size)
      SIZE_BYTE: begin
        st_word = {(DATA_WIDTH/8){st_data[7:0]}};
        st_be   = BE_WIDTH'(1) << offset;
      end
      SIZE_HALF: begin
        st_word = {(DATA_WIDTH/16){st_data[15:0]}};
        st_be   = BE_WIDTH'(3) << {offset[1], 1'b0};
      end
      default: begin
        st_word = st_data;
        st_be   = '1;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// DLX memory stage. It issues aligned loads and stores with a ready handshake
// and stalls upstream while an access is outstanding. It also registers the
// MEM/WB slot.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access in flight; accept EX/MEM slot (ALU op, misalign, mem op)
// ST_BUSY | request held on the bus until data_ready
module memory_access
  import dlx_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     alu_data_in,
  input  logic [DATA_WIDTH-1:0]     alu_b_data_in,
  input  logic                      mem_data_rd_en_in,
  input  logic                      mem_data_wr_en_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_signed_in,
  input  logic                      write_back_mux_sel_in,
  input  logic                      w_reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  output logic                      stall_out,
  output logic                      data_rd_en,
  output logic                      data_wr_en,
  output logic [ADDR_WIDTH-1:0]     data_addr,
  output logic [DATA_WIDTH-1:0]     data_write,
  output logic [BE_WIDTH-1:0]       data_be,
  input  logic [DATA_WIDTH-1:0]     data_read,
  input  logic                      data_ready,
  output logic                      valid_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH-1:0]     alu_data_out,
  output logic                      write_back_mux_sel_out,
  output logic                      w_reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
  output logic                      misalign_out
);

  ma_state_t state_q, state_d;

  // Slot captured at accept and held while the access is outstanding.
  logic [DATA_WIDTH-1:0]     acc_alu_q, acc_alu_d;
  logic [1:0]                acc_size_q, acc_size_d;
  logic                      acc_signed_q, acc_signed_d;
  logic                      acc_store_q, acc_store_d;
  logic                      acc_wb_sel_q, acc_wb_sel_d;
  logic                      acc_wen_q, acc_wen_d;
  logic [REG_ADDR_WIDTH-1:0] acc_waddr_q, acc_waddr_d;

  // Bus request fields, stable for the whole of ST_BUSY.
  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;
  logic [BE_WIDTH-1:0]       req_be_q, req_be_d;

  // MEM/WB slot.
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0]     alu_out_q, alu_out_d;
  logic                      wb_sel_q, wb_sel_d;
  logic                      wen_q, wen_d;
  logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                      misalign_q, misalign_d;

  logic                      busy;
  logic                      is_mem;
  logic                      mis_in;
  logic [1:0]                al_offset;
  logic [1:0]                al_size;
  logic                      al_signed;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic [DATA_WIDTH-1:0]     st_word;
  logic [BE_WIDTH-1:0]       st_be;

  // One aligner is shared. In IDLE it shapes the incoming store. In BUSY it
  // extracts the load lane from the captured address.
  always_comb begin
    busy      = (state_q == ST_BUSY);
    is_mem    = mem_data_rd_en_in | mem_data_wr_en_in;
    mis_in    = is_misaligned(mem_size_in, alu_data_in[1:0]);
    al_offset = busy ? acc_alu_q[1:0] : alu_data_in[1:0];
    al_size   = busy ? acc_size_q     : mem_size_in;
    al_signed = busy ? acc_signed_q   : mem_signed_in;
  end

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset    (al_offset),
    .size      (al_size),
    .is_signed (al_signed),
    .rd_word   (data_read),
    .st_data   (alu_b_data_in),
    .ld_data   (ld_data),
    .st_word   (st_word),
    .st_be     (st_be)
  );

  // Next-state and slot update; per-slot pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    acc_alu_d    = acc_alu_q;
    acc_size_d   = acc_size_q;
    acc_signed_d = acc_signed_q;
    acc_store_d  = acc_store_q;
    acc_wb_sel_d = acc_wb_sel_q;
    acc_wen_d    = acc_wen_q;
    acc_waddr_d  = acc_waddr_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    req_be_d     = req_be_q;
    valid_d      = 1'b0;
    misalign_d   = 1'b0;
    wen_d        = 1'b0;
    mem_data_d   = mem_data_q;
    alu_out_d    = alu_out_q;
    wb_sel_d     = wb_sel_q;
    waddr_d      = waddr_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (!is_mem || mis_in) begin
            // ALU op, or a faulting access reported in place of a request.
            valid_d    = 1'b1;
            misalign_d = is_mem;
            wen_d      = w_reg_wr_en_in & ~is_mem;
            alu_out_d  = alu_data_in;
            wb_sel_d   = write_back_mux_sel_in;
            waddr_d    = w_reg_addr_in;
          end else begin
            state_d      = ST_BUSY;
            acc_alu_d    = alu_data_in;
            acc_size_d   = mem_size_in;
            acc_signed_d = mem_signed_in;
            acc_store_d  = mem_data_wr_en_in;  // rd+wr together is a store
            acc_wb_sel_d = write_back_mux_sel_in;
            acc_wen_d    = w_reg_wr_en_in;
            acc_waddr_d  = w_reg_addr_in;
            req_addr_d   = {alu_data_in[ADDR_WIDTH-1:2], 2'b00};
            req_wdata_d  = st_word;
            req_be_d     = st_be;
          end
        end
      end
      ST_BUSY: begin
        if (data_ready) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          wen_d     = acc_wen_q & ~acc_store_q;
          alu_out_d = acc_alu_q;
          wb_sel_d  = acc_wb_sel_q;
          waddr_d   = acc_waddr_q;
          if (!acc_store_q) begin
            mem_data_d = ld_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_alu_q    <= '0;
      acc_size_q   <= '0;
      acc_signed_q <= 1'b0;
      acc_store_q  <= 1'b0;
      acc_wb_sel_q <= 1'b0;
      acc_wen_q    <= 1'b0;
      acc_waddr_q  <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
      valid_q      <= 1'b0;
      mem_data_q   <= '0;
      alu_out_q    <= '0;
      wb_sel_q     <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_alu_q    <= acc_alu_d;
      acc_size_q   <= acc_size_d;
      acc_signed_q <= acc_signed_d;
      acc_store_q  <= acc_store_d;
      acc_wb_sel_q <= acc_wb_sel_d;
      acc_wen_q    <= acc_wen_d;
      acc_waddr_q  <= acc_waddr_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      req_be_q     <= req_be_d;
      valid_q      <= valid_d;
      mem_data_q   <= mem_data_d;
      alu_out_q    <= alu_out_d;
      wb_sel_q     <= wb_sel_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      misalign_q   <= misalign_d;
    end
  end

  // Requests come straight from state, so a reset drops them at the same edge.
  always_comb begin
    stall_out              = busy & ~data_ready;
    data_rd_en             = busy & ~acc_store_q;
    data_wr_en             = busy & acc_store_q;
    data_addr              = req_addr_q;
    data_write             = req_wdata_q;
    data_be                = req_be_q;
    valid_out              = valid_q;
    mem_data_out           = mem_data_q;
    alu_data_out           = alu_out_q;
    write_back_mux_sel_out = wb_sel_q;
    w_reg_wr_en_out        = wen_q;
    w_reg_addr_out         = waddr_q;
    misalign_out           = misalign_q;
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomised bench for memory_access, checked against a transaction-level model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_data_in = '0;
  logic [31:0] alu_b_data_in = '0;
  logic        mem_data_rd_en_in = 1'b0;
  logic        mem_data_wr_en_in = 1'b0;
  logic [1:0]  mem_size_in = '0;
  logic        mem_signed_in = 1'b0;
  logic        write_back_mux_sel_in = 1'b0;
  logic        w_reg_wr_en_in = 1'b0;
  logic [4:0]  w_reg_addr_in = '0;
  logic        stall_out, data_rd_en, data_wr_en;
  logic [31:0] data_addr, data_write;
  logic [3:0]  data_be;
  logic [31:0] data_read = '0;
  logic        data_ready = 1'b0;
  logic        valid_out;
  logic [31:0] mem_data_out, alu_data_out;
  logic        write_back_mux_sel_out, w_reg_wr_en_out, misalign_out;
  logic [4:0]  w_reg_addr_out;

  memory_access dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .alu_data_in(alu_data_in), .alu_b_data_in(alu_b_data_in),
    .mem_data_rd_en_in(mem_data_rd_en_in), .mem_data_wr_en_in(mem_data_wr_en_in),
    .mem_size_in(mem_size_in), .mem_signed_in(mem_signed_in),
    .write_back_mux_sel_in(write_back_mux_sel_in), .w_reg_wr_en_in(w_reg_wr_en_in),
    .w_reg_addr_in(w_reg_addr_in), .stall_out(stall_out),
    .data_rd_en(data_rd_en), .data_wr_en(data_wr_en), .data_addr(data_addr),
    .data_write(data_write), .data_be(data_be), .data_read(data_read),
    .data_ready(data_ready), .valid_out(valid_out), .mem_data_out(mem_data_out),
    .alu_data_out(alu_data_out), .write_back_mux_sel_out(write_back_mux_sel_out),
    .w_reg_wr_en_out(w_reg_wr_en_out), .w_reg_addr_out(w_reg_addr_out),
    .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        wsel;
    logic        wen;
    logic        mis;
    logic [4:0]  waddr;
  } exp_t;

  exp_t        expq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] last_mem = '0;
  logic [31:0] seen_be, seen_write;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rdv, input int off,
                                             input int sz, input bit sgn);
    longint v;
    if (sz >= 2) return rdv;
    if (sz == 0) begin
      v = longint'((rdv >> (8 * off)) & 32'hFF);
      if (sgn && v >= 128) v = v - 256;
    end else begin
      v = longint'((rdv >> (8 * off)) & 32'hFFFF);
      if (sgn && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_be(input int off, input int sz);
    if (sz == 0) return 32'(1 << off);
    if (sz == 1) return (off >= 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Per-cycle comparison of the MEM/WB slot against the model's expected slots.
  initial begin
    exp_t e;
    bit   due_now;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (expq.size() > 0 && expq[0].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL slot_missed: expected valid_out at cycle %0d, now %0d", expq[0].due, cyc);
        void'(expq.pop_front());
      end
      due_now = (expq.size() > 0) && (expq[0].due == cyc);
      chk("valid_out", 32'(valid_out), 32'(due_now));
      if (due_now) begin
        e = expq.pop_front();
        chk("alu_data_out", alu_data_out, e.alu);
        chk("mem_data_out", mem_data_out, e.mem);
        chk("wb_sel_out", 32'(write_back_mux_sel_out), 32'(e.wsel));
        chk("w_reg_wr_en_out", 32'(w_reg_wr_en_out), 32'(e.wen));
        chk("w_reg_addr_out", 32'(w_reg_addr_out), 32'(e.waddr));
        chk("misalign_out", 32'(misalign_out), 32'(e.mis));
      end else begin
        chk("idle_misalign", 32'(misalign_out), 32'h0);
        chk("idle_wen", 32'(w_reg_wr_en_out), 32'h0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_out), 0);
    chk({tag, "_rd_en"}, 32'(data_rd_en), 0);
    chk({tag, "_wr_en"}, 32'(data_wr_en), 0);
    chk({tag, "_addr"}, data_addr, 0);
    chk({tag, "_write"}, data_write, 0);
    chk({tag, "_be"}, 32'(data_be), 0);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_mem"}, mem_data_out, 0);
    chk({tag, "_alu"}, alu_data_out, 0);
    chk({tag, "_wsel"}, 32'(write_back_mux_sel_out), 0);
    chk({tag, "_wen"}, 32'(w_reg_wr_en_out), 0);
    chk({tag, "_waddr"}, 32'(w_reg_addr_out), 0);
    chk({tag, "_mis"}, 32'(misalign_out), 0);
  endtask

  task automatic scramble_inputs(input bit v);
    valid_in              = v;
    alu_data_in           = $urandom;
    alu_b_data_in         = $urandom;
    mem_data_rd_en_in     = 1'($urandom);
    mem_data_wr_en_in     = 1'($urandom);
    mem_size_in           = 2'($urandom);
    mem_signed_in         = 1'($urandom);
    write_back_mux_sel_in = 1'($urandom);
    w_reg_wr_en_in        = 1'($urandom);
    w_reg_addr_in         = 5'($urandom);
  endtask

  // Present one instruction, serve its memory access after k wait cycles and
  // record the slot the model expects. Returns at the cycle valid_out should be up.
  task automatic do_op(input bit rd, input bit wr, input int sz, input bit sgn,
                       input logic [31:0] alu, input logic [31:0] bdata,
                       input bit wben, input bit wsel, input logic [4:0] waddr,
                       input int k, input logic [31:0] rdata);
    exp_t e;
    int   acc;
    int   off;
    bit   is_mem, mis;
    @(negedge clk);
    valid_in = 1'b1;
    alu_data_in = alu; alu_b_data_in = bdata;
    mem_data_rd_en_in = rd; mem_data_wr_en_in = wr;
    mem_size_in = sz[1:0]; mem_signed_in = sgn;
    write_back_mux_sel_in = wsel; w_reg_wr_en_in = wben; w_reg_addr_in = waddr;
    data_ready = 1'b0;
    acc    = cyc + 1;
    off    = int'(alu % 4);
    is_mem = rd || wr;
    mis    = is_mem && ((sz == 1 && (off % 2) != 0) || (sz >= 2 && off != 0));
    e.alu = alu; e.wsel = wsel; e.waddr = waddr; e.mis = mis;
    e.wen = wben && !wr && !mis;
    if (is_mem && !mis && !wr) last_mem = model_load(rdata, off, sz, sgn);
    e.mem = last_mem;
    e.due = (is_mem && !mis) ? acc + k + 1 : acc;
    expq.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
    if (is_mem && !mis) begin
      for (int i = 0; i < k; i++) begin
        scramble_inputs(1'($urandom));
        data_ready = 1'b0;
        #1;
        chk("stall_wait", 32'(stall_out), 1);
        chk("rd_en_wait", 32'(data_rd_en), 32'(!wr));
        chk("wr_en_wait", 32'(data_wr_en), 32'(wr));
        chk("addr_wait", data_addr, alu & 32'hFFFF_FFFC);
        if (wr) begin
          chk("be_wait", 32'(data_be), model_be(off, sz));
          chk("write_wait", data_write, model_wdata(bdata, sz));
        end
        @(negedge clk);
      end
      scramble_inputs(1'($urandom));
      data_ready = 1'b1;
      data_read  = rdata;
      #1;
      chk("stall_ready", 32'(stall_out), 0);
      chk("rd_en_ready", 32'(data_rd_en), 32'(!wr));
      chk("wr_en_ready", 32'(data_wr_en), 32'(wr));
      chk("addr_ready", data_addr, alu & 32'hFFFF_FFFC);
      if (wr) begin
        chk("be_ready", 32'(data_be), model_be(off, sz));
        chk("write_ready", data_write, model_wdata(bdata, sz));
      end
      seen_be    = 32'(data_be);
      seen_write = data_write;
      @(negedge clk);
      data_ready = 1'b0;
      valid_in   = 1'b0;
    end else begin
      #1;
      chk("no_req_rd", 32'(data_rd_en), 0);
      chk("no_req_wr", 32'(data_wr_en), 0);
      chk("no_req_stall", 32'(stall_out), 0);
    end
  endtask

  initial begin
    int          kind, sz, k;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // ALU-only op
    do_op(0, 0, 2, 0, 32'h0000_1234, 32'h0, 1, 0, 5'd7, 0, 32'h0);
    chk("alu_only_valid", 32'(valid_out), 1);
    chk("alu_only_data", alu_data_out, 32'h1234);
    chk("alu_only_wen", 32'(w_reg_wr_en_out), 1);
    chk("alu_only_waddr", 32'(w_reg_addr_out), 7);

    // signed byte load at 0x103, three wait cycles
    do_op(1, 0, 0, 1, 32'h0000_0103, 32'h0, 1, 1, 5'd3, 3, 32'h8012_3456);
    chk("sb_valid", 32'(valid_out), 1);
    chk("sb_data", mem_data_out, 32'hFFFF_FF80);

    // unsigned half load at 0x202, immediate ready
    do_op(1, 0, 1, 0, 32'h0000_0202, 32'h0, 1, 1, 5'd4, 0, 32'h8001_5555);
    chk("uh_data", mem_data_out, 32'h0000_8001);

    // byte store of 0xAB at 0x301
    do_op(0, 1, 0, 0, 32'h0000_0301, 32'h0000_00AB, 1, 0, 5'd9, 0, 32'h0);
    chk("sb_store_be", seen_be, 32'h2);
    chk("sb_store_write", seen_write, 32'hABAB_ABAB);
    chk("sb_store_wen", 32'(w_reg_wr_en_out), 0);

    // misaligned word load at 0x402
    do_op(1, 0, 2, 0, 32'h0000_0402, 32'h0, 1, 1, 5'd5, 0, 32'h0);
    chk("mis_flag", 32'(misalign_out), 1);
    chk("mis_wen", 32'(w_reg_wr_en_out), 0);
    chk("mis_alu", alu_data_out, 32'h402);

    // reset while BUSY, then a late data_ready must be ignored
    @(negedge clk);
    valid_in = 1'b1; alu_data_in = 32'h500; mem_data_rd_en_in = 1'b1;
    mem_data_wr_en_in = 1'b0; mem_size_in = 2'b10; w_reg_wr_en_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("busy_before_rst", 32'(data_rd_en), 1);
    @(negedge clk);
    rst = 1'b1;
    expq.delete();
    last_mem = '0;
    @(negedge clk);
    #1;
    check_zero("midrst");
    rst = 1'b0;
    data_ready = 1'b1;
    data_read = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_valid", 32'(valid_out), 0);
      chk("post_rst_rd_en", 32'(data_rd_en), 0);
    end
    data_ready = 1'b0;

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        scramble_inputs(1'b0);
      end
      kind = $urandom_range(0, 3);
      sz   = $urandom_range(0, 3);
      k    = $urandom_range(0, 3);
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      do_op(kind == 1 || kind == 3, kind >= 2, sz, 1'($urandom), a, $urandom,
            1'($urandom), 1'($urandom), 5'($urandom), k, $urandom);
    end
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover_slots: %0d expected slots never seen", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
